pic_irq_core: RTL

Parametrised, fully synchronous successor to the 8259 control logic. One engine holds IRR, IMR and ISR for NUM_IRQ request lines, and provides a rotating-priority resolver, a two-pulse acknowledge FSM, vector generation, EOI and AEOI, and auto-rotation. It sits between the read/write command decoder (upstream) and the data buffer and cascade logic (downstream).

---
 rtl/pic_pkg.sv | 24 ++
 rtl/pic_prio_resolver.sv | 37 +++
 rtl/pic_irq_core.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pic_pkg: command codes and acknowledge FSM encoding for the        |
// | pic_irq_core interrupt engine.                                     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pic_pkg;

   localparam logic [2:0] CMD_ROT_AEOI_CLR = 3'b000;
   localparam logic [2:0] CMD_NSEOI        = 3'b001;
   localparam logic [2:0] CMD_NOP          = 3'b010;
   localparam logic [2:0] CMD_SEOI         = 3'b011;
   localparam logic [2:0] CMD_ROT_AEOI_SET = 3'b100;
   localparam logic [2:0] CMD_ROT_NSEOI    = 3'b101;
   localparam logic [2:0] CMD_SET_PRIO     = 3'b110;
   localparam logic [2:0] CMD_ROT_SEOI     = 3'b111;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACK1 = 1'b1
   } pic_state_t;

endpackage
`default_nettype wire

// File: rtl/pic_prio_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pic_prio_resolver: combinational rotating-priority find-first.     |
// | Highest priority is (prio_bottom+1) mod NUM_IRQ, descending.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pic_prio_resolver #(
   parameter  int NUM_IRQ = 8,
   localparam int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] req,
   input  logic [ID_W-1:0]    prio_bottom,
   output logic [ID_W-1:0]    id,
   output logic               found
);

   function automatic logic [ID_W-1:0] lvl_of(input int k, input logic [ID_W-1:0] pb);
      int l;
      l = int'(pb) + 1 + k;
      if (l >= NUM_IRQ) l = l - NUM_IRQ;
      return l[ID_W-1:0];
   endfunction

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      id    = '0;
      found = 1'b0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (req[lvl_of(k, prio_bottom)]) begin
            id    = lvl_of(k, prio_bottom);
            found = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pic_irq_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pic_irq_core: IRR/IMR/ISR engine with rotating priority, two-pulse |
// | acknowledge, EOI/AEOI and auto-rotation. Macro SPECIAL_MASK_EN     |
// | adds the smm input (special mask mode).                            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pic_irq_core
   import pic_pkg::*;
#(
   parameter  int NUM_IRQ  = 8,
   parameter  int VECTOR_W = 8,
   localparam int ID_W     = $clog2(NUM_IRQ)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_IRQ-1:0]  irq_in,
   input  logic                cfg_level,
   input  logic                cfg_aeoi,
   input  logic [VECTOR_W-1:0] cfg_vector_base,
   input  logic                imr_wr,
   input  logic [NUM_IRQ-1:0]  imr_wdata,
   input  logic                cmd_valid,
   input  logic [2:0]          cmd_op,
   input  logic [ID_W-1:0]     cmd_level,
   input  logic                inta_pulse,
`ifdef SPECIAL_MASK_EN
   input  logic                smm,
`endif
   output logic                int_out,
   output logic [VECTOR_W-1:0] vector_out,
   output logic                vector_valid,
   output logic [NUM_IRQ-1:0]  irr_out,
   output logic [NUM_IRQ-1:0]  isr_out,
   output logic [NUM_IRQ-1:0]  imr_out,
   output logic [ID_W-1:0]     prio_bottom
);

   localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_IRQ - 1);

   pic_state_t          r_state, w_state_nxt;
   logic [NUM_IRQ-1:0]  r_irr, r_isr, r_imr, r_irq_q;
   logic [NUM_IRQ-1:0]  w_irr_nxt, w_isr_nxt, w_req, w_isr_eff, w_eoi_clr;
   logic [ID_W-1:0]     r_prio_bottom, r_sel_id, w_pb_nxt;
   logic [ID_W-1:0]     w_cand_id, w_top_id, w_cmd_rot_id;
   logic                w_cand_found, w_top_found, w_pending;
   logic                r_spurious, r_auto_rotate, r_int, r_vector_valid;
   logic                w_ack_first, w_ack_second, w_aeoi_now;
   logic                w_cmd_rot, w_ar_set, w_ar_clr, w_lvl_ok;
   logic [VECTOR_W-1:0] r_vector;

   function automatic logic [ID_W-1:0] rank_of(input logic [ID_W-1:0] lvl,
                                               input logic [ID_W-1:0] pb);
      int r;
      r = int'(lvl) + NUM_IRQ - int'(pb) - 1;
      if (r >= NUM_IRQ) r = r - NUM_IRQ;
      return r[ID_W-1:0];
   endfunction

   assign w_req = r_irr & ~r_imr;
`ifdef SPECIAL_MASK_EN
   // Masked in-service levels stop blocking lower levels while smm is set.
   assign w_isr_eff = smm ? (r_isr & ~r_imr) : r_isr;
`else
   assign w_isr_eff = r_isr;
`endif

   pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_cand_res (
      .req         (w_req),
      .prio_bottom (r_prio_bottom),
      .id          (w_cand_id),
      .found       (w_cand_found)
   );

   pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_res (
      .req         (w_isr_eff),
      .prio_bottom (r_prio_bottom),
      .id          (w_top_id),
      .found       (w_top_found)
   );

   assign w_pending = w_cand_found &&
                      (!w_top_found ||
                       (rank_of(w_cand_id, r_prio_bottom) < rank_of(w_top_id, r_prio_bottom)));

   assign w_ack_first  = (r_state == ST_IDLE) && inta_pulse;
   assign w_ack_second = (r_state == ST_ACK1) && inta_pulse;
   assign w_aeoi_now   = w_ack_second && cfg_aeoi && !r_spurious;
   assign w_lvl_ok     = int'(cmd_level) < NUM_IRQ;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (inta_pulse) w_state_nxt = ST_ACK1;
         ST_ACK1: if (inta_pulse) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // EOI decisions are taken on the ISR as it stood before this edge.
   always_comb begin
      w_eoi_clr    = '0;
      w_cmd_rot    = 1'b0;
      w_cmd_rot_id = cmd_level;
      w_ar_set     = 1'b0;
      w_ar_clr     = 1'b0;
      if (cmd_valid) begin
         case (cmd_op)
            CMD_NSEOI: begin
               if (w_top_found) w_eoi_clr[w_top_id] = 1'b1;
            end
            CMD_ROT_NSEOI: begin
               if (w_top_found) begin
                  w_eoi_clr[w_top_id] = 1'b1;
                  w_cmd_rot           = 1'b1;
                  w_cmd_rot_id        = w_top_id;
               end
            end
            CMD_SEOI: begin
               if ((|r_isr) && w_lvl_ok) w_eoi_clr[cmd_level] = 1'b1;
            end
            CMD_ROT_SEOI: begin
               if ((|r_isr) && w_lvl_ok) begin
                  w_eoi_clr[cmd_level] = 1'b1;
                  w_cmd_rot            = 1'b1;
               end
            end
            CMD_SET_PRIO:     w_cmd_rot = w_lvl_ok;
            CMD_ROT_AEOI_SET: w_ar_set  = 1'b1;
            CMD_ROT_AEOI_CLR: w_ar_clr  = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_irr_nxt = cfg_level ? irq_in : (r_irr | (irq_in & ~r_irq_q));
      w_isr_nxt = r_isr & ~w_eoi_clr;
      w_pb_nxt  = r_prio_bottom;
      if (w_aeoi_now) begin
         w_isr_nxt[r_sel_id] = 1'b0;
         if (r_auto_rotate) w_pb_nxt = r_sel_id;
      end
      // The acknowledge set is applied last so it beats a same-cycle EOI.
      if (w_ack_first && w_cand_found) begin
         w_irr_nxt[w_cand_id] = 1'b0;
         w_isr_nxt[w_cand_id] = 1'b1;
      end
      if (w_cmd_rot) w_pb_nxt = w_cmd_rot_id;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_irr          <= '0;
         r_isr          <= '0;
         r_imr          <= '1;
         r_irq_q        <= '0;
         r_prio_bottom  <= c_last_id;
         r_sel_id       <= c_last_id;
         r_spurious     <= 1'b0;
         r_auto_rotate  <= 1'b0;
         r_int          <= 1'b0;
         r_vector       <= '0;
         r_vector_valid <= 1'b0;
      end else begin
         r_irq_q        <= irq_in;
         r_irr          <= w_irr_nxt;
         r_isr          <= w_isr_nxt;
         r_prio_bottom  <= w_pb_nxt;
         r_int          <= w_pending && (w_state_nxt == ST_IDLE);
         r_vector_valid <= w_ack_second;
         if (imr_wr) r_imr <= imr_wdata;
         if (w_ar_set) r_auto_rotate <= 1'b1;
         else if (w_ar_clr) r_auto_rotate <= 1'b0;
         if (w_ack_first) begin
            r_sel_id   <= w_cand_found ? w_cand_id : c_last_id;
            r_spurious <= !w_cand_found;
         end
         if (w_ack_second) r_vector <= cfg_vector_base + VECTOR_W'(r_sel_id);
      end
   end

   assign int_out      = r_int;
   assign vector_out   = r_vector;
   assign vector_valid = r_vector_valid;
   assign irr_out      = r_irr;
   assign isr_out      = r_isr;
   assign imr_out      = r_imr;
   assign prio_bottom  = r_prio_bottom;

endmodule
`default_nettype wire
